// File: rtl/addru_pkg.sv
// Shared types and sizing helpers for the digit-serial adder.
package addru_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS1 = 2'd1,
    PASS2 = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int CHECK_NONE = 0;
  localparam int CHECK_TR   = 1;

  // Number of digits needed to cover the operand width.
  function automatic int num_digits(input int width, input int digit);
    if (digit <= 0) return 1;
    return width / digit;
  endfunction

  // Width of the digit index register; never narrower than one bit.
  function automatic int idx_width(input int width, input int digit);
    int n;
    n = num_digits(width, digit);
    if (n <= 1) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/addru_digit.sv
// Combinational DIGIT-bit ripple-carry adder slice.
module addru_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             cin,
  output logic [DIGIT-1:0] s_d,
  output logic             cout
);

  logic [DIGIT:0] c;

  // Bit-level ripple chain from cin through to cout.
  always_comb begin
    s_d  = '0;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      s_d[i]   = a_d[i] ^ b_d[i] ^ c[i];
      c[i+1]   = (a_d[i] & b_d[i]) | (c[i] & (a_d[i] ^ b_d[i]));
    end
    cout = c[DIGIT];
  end

endmodule

// File: rtl/addru_serial_tr.sv
// Digit-serial unsigned adder with optional time-redundant self-check.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready high
// PASS1 | adding A+B one digit per cycle into acc1
// PASS2 | re-adding as B+A into acc2 (CHECK=1 only); inj corrupts a digit
// DONE  | result presented on sum/err with out_valid until out_ready
module addru_serial_tr
  import addru_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4,
  parameter int CHECK = CHECK_TR,
  parameter int ERRW  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             inj,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             err,
  output logic [ERRW-1:0]  err_cnt
);

  localparam int N        = num_digits(WIDTH, DIGIT);
  localparam int IDX_W    = idx_width(WIDTH, DIGIT);
  localparam bit DO_CHECK = (CHECK == CHECK_TR);

  if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("addru_serial_tr: WIDTH must be a positive multiple of DIGIT");
  end

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH:0]   acc1;
  logic [WIDTH:0]   acc2;
  logic             carry;
  logic [IDX_W-1:0] idx;

  logic             pass2;
  logic             last;
  int               base;
  logic [DIGIT-1:0] dig_a;
  logic [DIGIT-1:0] dig_b;
  logic [DIGIT-1:0] add_a;
  logic [DIGIT-1:0] add_b;
  logic [DIGIT-1:0] s_d;
  logic [DIGIT-1:0] s_fix;
  logic             cout;
  logic [WIDTH:0]   mask;
  logic [WIDTH:0]   acc_sel;
  logic [WIDTH:0]   acc_nxt;

  // Digit selection, operand swap for the check pass, and accumulator merge.
  always_comb begin
    pass2   = (state == PASS2);
    last    = (idx == IDX_W'(N - 1));
    base    = int'(idx) * DIGIT;
    dig_a   = DIGIT'(op_a >> base);
    dig_b   = DIGIT'(op_b >> base);
    add_a   = pass2 ? dig_b : dig_a;
    add_b   = pass2 ? dig_a : dig_b;
    s_fix   = s_d;
    s_fix[0] = s_d[0] ^ (inj & pass2 & DO_CHECK);
    mask    = (WIDTH+1)'({DIGIT{1'b1}});
    acc_sel = pass2 ? acc2 : acc1;
    acc_nxt = (acc_sel & ~(mask << base)) | ((WIDTH+1)'(s_fix) << base);
    if (last) acc_nxt[WIDTH] = cout;
  end

  addru_digit #(.DIGIT(DIGIT)) u_digit (
    .a_d  (add_a),
    .b_d  (add_b),
    .cin  (carry),
    .s_d  (s_d),
    .cout (cout)
  );

  // Control FSM with all datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_a      <= '0;
      op_b      <= '0;
      acc1      <= '0;
      acc2      <= '0;
      carry     <= 1'b0;
      idx       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      err       <= 1'b0;
      err_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a     <= a;
            op_b     <= b;
            acc1     <= '0;
            acc2     <= '0;
            carry    <= 1'b0;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= PASS1;
          end
        end
        PASS1: begin
          acc1  <= acc_nxt;
          carry <= cout;
          if (last) begin
            idx   <= '0;
            carry <= 1'b0;
            if (DO_CHECK) begin
              state <= PASS2;
            end else begin
              state     <= DONE;
              sum       <= acc_nxt;
              err       <= 1'b0;
              out_valid <= 1'b1;
            end
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        PASS2: begin
          acc2  <= acc_nxt;
          carry <= cout;
          if (last) begin
            idx       <= '0;
            carry     <= 1'b0;
            state     <= DONE;
            sum       <= acc1;
            err       <= (acc1 != acc_nxt);
            out_valid <= 1'b1;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            if (err && (err_cnt != '1)) err_cnt <= err_cnt + ERRW'(1);
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
